// File: rtl/wb_port_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant per transfer.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   req0, req1, gnt_cyc, wd_fire;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign gnt_cyc = (state_q == StGnt1) ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        timeout_q;

  // A real ack in the same cycle always wins over the watchdog.
  assign wd_fire = (state_q != StIdle) & gnt_cyc & ~s_ack_i &
                   (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == StIdle) ? 16'd0 : cnt_q + 16'd1;
      timeout_q <= timeout_q | wd_fire;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES ^ gnt_cyc;
  assign wd_fire    = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) state_d = last_gnt_q ? StGnt0 : StGnt1;
        else if (req0)    state_d = StGnt0;
        else if (req1)    state_d = StGnt1;
      end
      StGnt0: begin
        if (s_ack_i || !m0_cyc_i || wd_fire) begin
          state_d    = StIdle;
          last_gnt_d = 1'b0;
        end
      end
      StGnt1: begin
        if (s_ack_i || !m1_cyc_i || wd_fire) begin
          state_d    = StIdle;
          last_gnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i & ~wd_fire;
        s_stb_o  = m0_stb_i & ~wd_fire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i | wd_fire;
        m0_dat_o = wd_fire ? 32'hDEAD_DEAD : s_dat_i;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i & ~wd_fire;
        s_stb_o  = m1_stb_i & ~wd_fire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i | wd_fire;
        m1_dat_o = wd_fire ? 32'hDEAD_DEAD : s_dat_i;
      end
      default: ;
    endcase
  end

  assign grant_o = {state_q == StGnt1, state_q == StGnt0};

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; watchdog case runs only
// when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .m0_cyc_i (m0_cyc),  .m0_stb_i (m0_stb),  .m0_we_i (m0_we),   .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr),  .m0_dat_i (m0_wdat), .m0_ack_o (m0_ack), .m0_dat_o (m0_rdat),
    .m1_cyc_i (m1_cyc),  .m1_stb_i (m1_stb),  .m1_we_i (m1_we),   .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr),  .m1_dat_i (m1_wdat), .m1_ack_o (m1_ack), .m1_dat_o (m1_rdat),
    .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),   .s_we_o   (s_we),   .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),   .s_dat_o  (s_wdat),  .s_ack_i  (s_ack),  .s_dat_i  (s_rdat),
    .grant_o  (grant),   .timeout_o (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle away from the edge before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdat = dat;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = 4'h3; m1_adr = adr; m1_wdat = dat;
  endtask

  initial begin
    int n0, n1;
    logic [1:0] exp_g;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    s_rdat = 32'h0;
    do_reset();

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_scyc", 32'(s_cyc), 32'h0);
    check("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // m0 single write, slave acks in second granted cycle
    m0_req(1'b1, 1'b1, 32'h3000_0000, 32'h1234_5678);
    #1;
    check("idle_scyc_pending", 32'(s_cyc), 32'h0);
    tick();
    check("wr_grant", 32'(grant), 32'h1);
    check("wr_sadr", s_adr, 32'h3000_0000);
    check("wr_sdat", s_wdat, 32'h1234_5678);
    check("wr_sctl", 32'({s_cyc, s_stb, s_we, s_sel}), 32'h7F);
    check("wr_noack", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 1'b1;
    #1;
    check("wr_ack", 32'(m0_ack), 32'h1);
    check("wr_m1_noack", 32'(m1_ack), 32'h0);
    tick();
    s_ack = 1'b0;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("wr_idle_grant", 32'(grant), 32'h0);
    check("wr_ack_done", 32'(m0_ack), 32'h0);

    // Simultaneous requests right after reset: strict alternation, m0 first
    do_reset();
    n0 = 3;
    n1 = 3;
    m0_req(1'b1, 1'b0, 32'h100, 32'h0);
    m1_req(1'b1, 1'b0, 32'h200, 32'h0);
    for (int t = 0; t < 6; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("rr_grant%0d", t), 32'(grant), 32'(exp_g));
      s_ack = 1'b1;
      #1;
      check($sformatf("rr_acks%0d", t), 32'({m1_ack, m0_ack}), 32'(exp_g));
      tick();
      s_ack = 1'b0;
      if (exp_g == 2'b01) n0--; else n1--;
      if (n0 == 0) m0_req(1'b0, 1'b0, 32'h0, 32'h0);
      if (n1 == 0) m1_req(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check($sformatf("rr_idle%0d", t), 32'(grant), 32'h0);
    end

    // m1 read
    m1_req(1'b1, 1'b0, 32'h3000_0040, 32'h0);
    tick();
    check("rd_grant", 32'(grant), 32'h2);
    check("rd_m0dat_pre", m0_rdat, 32'h0);
    s_ack = 1'b1;
    s_rdat = 32'hCAFE_F00D;
    #1;
    check("rd_m1dat", m1_rdat, 32'hCAFE_F00D);
    check("rd_m1ack", 32'(m1_ack), 32'h1);
    check("rd_m0dat", m0_rdat, 32'h0);
    check("rd_m0ack", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 1'b0;
    s_rdat = 32'h0;
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);

    // m0 aborts 3 cycles into its grant while m1 waits
    m0_req(1'b1, 1'b0, 32'h3000_0080, 32'h0);
    tick();
    check("ab_grant", 32'(grant), 32'h1);
    m1_req(1'b1, 1'b1, 32'h3000_00C0, 32'h5555_AAAA);
    tick();
    tick();
    tick();
    m0_cyc = 1'b0;
    #1;
    check("ab_scyc_drop", 32'(s_cyc), 32'h0);
    check("ab_grant_hold", 32'(grant), 32'h1);
    tick();
    s_ack = 1'b1;
    #1;
    check("ab_late_ack", 32'({m1_ack, m0_ack}), 32'h0);
    check("ab_idle", 32'(grant), 32'h0);
    tick();
    s_ack = 1'b0;
    #1;
    check("ab_m1_grant", 32'(grant), 32'h2);
    check("ab_m1_adr", s_adr, 32'h3000_00C0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: slave never acks an m0 read
    m0_req(1'b1, 1'b0, 32'h3000_0100, 32'h0);
    tick();
    for (int c = 1; c < 8; c++) begin
      check($sformatf("wd_wait%0d", c), 32'({m0_ack, grant}), 32'h1);
      tick();
    end
    check("wd_ack", 32'(m0_ack), 32'h1);
    check("wd_dat", m0_rdat, 32'hDEAD_DEAD);
    check("wd_scyc", 32'({s_cyc, s_stb}), 32'h0);
    tick();
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    m1_req(1'b1, 1'b0, 32'h3000_0140, 32'h0);
    #1;
    check("wd_flag", 32'(timeout), 32'h1);
    check("wd_idle", 32'(grant), 32'h0);
    tick();
    check("wd_m1_grant", 32'(grant), 32'h2);
    s_ack = 1'b1;
    #1;
    check("wd_m1_ack", 32'(m1_ack), 32'h1);
    tick();
    s_ack = 1'b0;
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("wd_flag_sticky", 32'(timeout), 32'h1);
`else
    check("no_wd_timeout", 32'(timeout), 32'h0);
`endif

    // Reset in the middle of an m1 transfer
    m1_req(1'b1, 1'b0, 32'h3000_0200, 32'h0);
    tick();
    check("mr_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_outs", 32'({grant, s_cyc, s_stb, m0_ack, m1_ack, timeout}), 32'h0);
    check("mr_sadr", s_adr, 32'h0);
    check("mr_m1dat", m1_rdat, 32'h0);
    m0_req(1'b1, 1'b0, 32'h3000_0300, 32'h0);
    tick();
    check("mr_tie_m0", 32'(grant), 32'h1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("mr_then_m1", 32'(grant), 32'h0);
    tick();
    check("mr_m1_grant", 32'(grant), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
